// File: rtl/video_depth_adapter.sv
// video_depth_adapter
//
// Colour-depth reducer placed between a core's RGB output and a narrower VGA DAC.
// Each channel gets a 4x4 ordered-dither threshold added, with saturation on carry,
// and is then truncated to OUT_W bits. The dither pattern can rotate every frame.
// Syncs and blanking go through the same two pipeline registers as the pixel.
//
// Build option:
//   VIDEO_DITHER_EN  defined   : dither, saturation and temporal rotation are active.
//                    undefined : plain truncation (no position counters), same latency.
//
// Parameters:
//   IN_W      core colour width per channel
//   OUT_W     DAC width per channel (1 <= OUT_W <= IN_W)
//   TEMPORAL  1 = rotate the dither pattern on every VS_IN rising edge
//
// Ports:
//   CLOCK, RESET_N        video clock, asynchronous active-low reset
//   CE_PIX                pixel enable; all state advances only when high
//   R_IN/G_IN/B_IN        input pixel, IN_W bits per channel
//   HS_IN/VS_IN           syncs, any polarity
//   HBLANK_IN/VBLANK_IN   active-high blanking
//   R_OUT/G_OUT/B_OUT     reduced pixel, OUT_W bits per channel, 2 CE_PIX latency
//   HS_OUT/VS_OUT         syncs delayed to match the pixel
//   DE_OUT                high during active video

module video_depth_adapter #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 6,
    parameter int TEMPORAL = 1
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             CE_PIX,
    input  logic [IN_W-1:0]  R_IN,
    input  logic [IN_W-1:0]  G_IN,
    input  logic [IN_W-1:0]  B_IN,
    input  logic             HS_IN,
    input  logic             VS_IN,
    input  logic             HBLANK_IN,
    input  logic             VBLANK_IN,
    output logic [OUT_W-1:0] R_OUT,
    output logic [OUT_W-1:0] G_OUT,
    output logic [OUT_W-1:0] B_OUT,
    output logic             HS_OUT,
    output logic             VS_OUT,
    output logic             DE_OUT
);

    localparam int DROP = IN_W - OUT_W;

    // Dither threshold added to every channel; always < 2^DROP.
    logic [IN_W-1:0] w_thr;

`ifdef VIDEO_DITHER_EN
    logic [1:0] r_x;
    logic [1:0] r_y;
    logic [1:0] r_f;
    logic       r_hblank_d;
    logic       r_vs_d;
    logic       w_hblank_rise;
    logic       w_vs_rise;
    logic [1:0] w_bx;
    logic [3:0] w_b;
    logic       w_unused_bayer;

    assign w_hblank_rise = HBLANK_IN & ~r_hblank_d;
    assign w_vs_rise     = VS_IN & ~r_vs_d;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x        <= '0;
            r_y        <= '0;
            r_f        <= '0;
            r_hblank_d <= 1'b0;
            r_vs_d     <= 1'b0;
        end else if (CE_PIX) begin
            r_hblank_d <= HBLANK_IN;
            r_vs_d     <= VS_IN;
            if (HBLANK_IN) begin
                r_x <= '0;
            end else begin
                r_x <= r_x + 2'd1;
            end
            // Vertical blank clear wins over a coincident line increment.
            if (VBLANK_IN) begin
                r_y <= '0;
            end else if (w_hblank_rise) begin
                r_y <= r_y + 2'd1;
            end
            if ((TEMPORAL != 0) && w_vs_rise) begin
                r_f <= r_f + 2'd1;
            end
        end
    end

    // Frame counter shifts the column index so the pattern walks across frames.
    assign w_bx = r_x + r_f;

    always_comb begin
        w_b = 4'd0;
        case ({r_y, w_bx})
            4'h0: w_b = 4'd0;
            4'h1: w_b = 4'd8;
            4'h2: w_b = 4'd2;
            4'h3: w_b = 4'd10;
            4'h4: w_b = 4'd12;
            4'h5: w_b = 4'd4;
            4'h6: w_b = 4'd14;
            4'h7: w_b = 4'd6;
            4'h8: w_b = 4'd3;
            4'h9: w_b = 4'd11;
            4'hA: w_b = 4'd1;
            4'hB: w_b = 4'd9;
            4'hC: w_b = 4'd15;
            4'hD: w_b = 4'd7;
            4'hE: w_b = 4'd13;
            4'hF: w_b = 4'd5;
            default: w_b = 4'd0;
        endcase
    end

    // Scale the 4-bit matrix value to the number of dropped bits.
    if (DROP == 0) begin : g_thr_none
        assign w_thr = '0;
    end else if (DROP <= 4) begin : g_thr_shr
        assign w_thr = IN_W'(w_b >> (4 - DROP));
    end else begin : g_thr_shl
        assign w_thr = IN_W'(w_b) << (DROP - 4);
    end

    // With DROP == 0 the matrix value has no consumer.
    assign w_unused_bayer = ^w_b;
`else
    logic w_unused_temporal;

    assign w_thr             = '0;
    assign w_unused_temporal = (TEMPORAL != 0);
`endif

    function automatic logic [IN_W-1:0] sat_add(input logic [IN_W-1:0] v,
                                                input logic [IN_W-1:0] t);
        logic [IN_W:0] sum;
        sum = {1'b0, v} + {1'b0, t};
        return sum[IN_W] ? {IN_W{1'b1}} : sum[IN_W-1:0];
    endfunction

    logic [IN_W-1:0] w_sat_r;
    logic [IN_W-1:0] w_sat_g;
    logic [IN_W-1:0] w_sat_b;
    logic            w_unused_low;

    assign w_sat_r = sat_add(R_IN, w_thr);
    assign w_sat_g = sat_add(G_IN, w_thr);
    assign w_sat_b = sat_add(B_IN, w_thr);

    // Bits below DROP are discarded by the truncation.
    assign w_unused_low = ^{w_sat_r, w_sat_g, w_sat_b};

    // Stage 1: dithered, saturated, already-truncated channels plus control.
    logic [OUT_W-1:0] r_s1_r;
    logic [OUT_W-1:0] r_s1_g;
    logic [OUT_W-1:0] r_s1_b;
    logic             r_s1_blank;
    logic             r_s1_hs;
    logic             r_s1_vs;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s1_blank <= 1'b1;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
        end else if (CE_PIX) begin
            r_s1_r     <= w_sat_r[IN_W-1:DROP];
            r_s1_g     <= w_sat_g[IN_W-1:DROP];
            r_s1_b     <= w_sat_b[IN_W-1:DROP];
            r_s1_blank <= HBLANK_IN | VBLANK_IN;
            r_s1_hs    <= HS_IN;
            r_s1_vs    <= VS_IN;
        end
    end

    // Stage 2: output registers; colour forced to black outside active video.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            R_OUT  <= '0;
            G_OUT  <= '0;
            B_OUT  <= '0;
            HS_OUT <= 1'b0;
            VS_OUT <= 1'b0;
            DE_OUT <= 1'b0;
        end else if (CE_PIX) begin
            R_OUT  <= r_s1_blank ? '0 : r_s1_r;
            G_OUT  <= r_s1_blank ? '0 : r_s1_g;
            B_OUT  <= r_s1_blank ? '0 : r_s1_b;
            HS_OUT <= r_s1_hs;
            VS_OUT <= r_s1_vs;
            DE_OUT <= ~r_s1_blank;
        end
    end

endmodule

// File: tb/tb_video_depth_adapter.sv
// tb_video_depth_adapter
//
// Directed bench for video_depth_adapter. Three instances share one stimulus stream:
//   u_dut  : IN_W=8, OUT_W=6, TEMPORAL=0
//   u_tmp  : IN_W=8, OUT_W=6, TEMPORAL=1
//   u_pass : IN_W=8, OUT_W=8 (pure 2-stage delay)
// Expected values are hand-computed; the dithered or truncated set is chosen by
// whether VIDEO_DITHER_EN is defined for the build.

module tb_video_depth_adapter;

`ifdef VIDEO_DITHER_EN
    localparam bit Dith = 1'b1;
`else
    localparam bit Dith = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [7:0] r_in, g_in, b_in;
    logic       hs, vs, hb, vb;

    logic [5:0] r_o, g_o, b_o;
    logic       hs_o, vs_o, de_o;
    logic [5:0] t_r, t_g, t_b;
    logic       t_hs, t_vs, t_de;
    logic [7:0] p_r, p_g, p_b;
    logic       p_hs, p_vs, p_de;

    int n_cmp = 0;
    int n_err = 0;

    video_depth_adapter #(.IN_W(8), .OUT_W(6), .TEMPORAL(0)) u_dut (
        .CLOCK(clk), .RESET_N(rst_n), .CE_PIX(ce),
        .R_IN(r_in), .G_IN(g_in), .B_IN(b_in),
        .HS_IN(hs), .VS_IN(vs), .HBLANK_IN(hb), .VBLANK_IN(vb),
        .R_OUT(r_o), .G_OUT(g_o), .B_OUT(b_o),
        .HS_OUT(hs_o), .VS_OUT(vs_o), .DE_OUT(de_o)
    );

    video_depth_adapter #(.IN_W(8), .OUT_W(6), .TEMPORAL(1)) u_tmp (
        .CLOCK(clk), .RESET_N(rst_n), .CE_PIX(ce),
        .R_IN(r_in), .G_IN(g_in), .B_IN(b_in),
        .HS_IN(hs), .VS_IN(vs), .HBLANK_IN(hb), .VBLANK_IN(vb),
        .R_OUT(t_r), .G_OUT(t_g), .B_OUT(t_b),
        .HS_OUT(t_hs), .VS_OUT(t_vs), .DE_OUT(t_de)
    );

    video_depth_adapter #(.IN_W(8), .OUT_W(8), .TEMPORAL(0)) u_pass (
        .CLOCK(clk), .RESET_N(rst_n), .CE_PIX(ce),
        .R_IN(r_in), .G_IN(g_in), .B_IN(b_in),
        .HS_IN(hs), .VS_IN(vs), .HBLANK_IN(hb), .VBLANK_IN(vb),
        .R_OUT(p_r), .G_OUT(p_g), .B_OUT(p_b),
        .HS_OUT(p_hs), .VS_OUT(p_vs), .DE_OUT(p_de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // er: 6-bit non-temporal, et: 6-bit temporal, ep: 8-bit passthrough, ede: DE.
    task automatic chk_px(input string tag, input logic [7:0] er, input logic [7:0] et,
                          input logic [7:0] ep, input logic ede);
        check({tag, "_r"}, 32'(r_o), 32'(er));
        check({tag, "_g"}, 32'(g_o), 32'(er));
        check({tag, "_b"}, 32'(b_o), 32'(er));
        check({tag, "_tr"}, 32'(t_r), 32'(et));
        check({tag, "_pr"}, 32'(p_r), 32'(ep));
        check({tag, "_pb"}, 32'(p_b), 32'(ep));
        check({tag, "_de"}, 32'(de_o), 32'(ede));
        check({tag, "_tde"}, 32'(t_de), 32'(ede));
        check({tag, "_pde"}, 32'(p_de), 32'(ede));
    endtask

    task automatic drive(input logic [7:0] v, input logic h, input logic vbk,
                         input logic s, input logic vsync);
        r_in = v;
        g_in = v;
        b_in = v;
        hb   = h;
        vb   = vbk;
        hs   = s;
        vs   = vsync;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        r_in  = '0;
        g_in  = '0;
        b_in  = '0;
        hb    = 1'b1;
        vb    = 1'b1;
        hs    = 1'b0;
        vs    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_px("rst", 8'h00, 8'h00, 8'h00, 1'b0);
        check("rst_hs", 32'(hs_o), 32'd0);
        check("rst_vs", 32'(vs_o), 32'd0);
        rst_n = 1'b1;

        // Vertical blank, then a horizontal blank before the first line (y=0).
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Line y=0, constant 0x82: thresholds 0,2,0,2.
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("lat", 8'h00, 8'h00, 8'h00, 1'b0);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("l0x0", 8'h20, 8'h20, 8'h82, 1'b1);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("l0x1", Dith ? 8'h21 : 8'h20, Dith ? 8'h21 : 8'h20, 8'h82, 1'b1);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("l0x2", 8'h20, 8'h20, 8'h82, 1'b1);
        // Blanked pixel with full-scale colour and HS asserted.
        drive(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_px("l0x3", Dith ? 8'h21 : 8'h20, Dith ? 8'h21 : 8'h20, 8'h82, 1'b1);
        check("hs_pre", 32'(hs_o), 32'd0);
        drive(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_px("hbl", 8'h00, 8'h00, 8'h00, 1'b0);
        check("hs_dly", 32'(hs_o), 32'd1);
        check("hs_pdly", 32'(p_hs), 32'd1);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hs_fall", 32'(hs_o), 32'd0);

        // Line y=1, x=0: threshold 3, 0x7D+3 = 0x80.
        drive(8'h7D, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_px("l1x0", Dith ? 8'h20 : 8'h1F, Dith ? 8'h20 : 8'h1F, 8'h7D, 1'b1);

        // Pixel enable low: outputs and internal state must hold.
        ce   = 1'b0;
        r_in = 8'h11;
        g_in = 8'h11;
        b_in = 8'h11;
        hb   = 1'b0;
        hs   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_px("frz", Dith ? 8'h20 : 8'h1F, Dith ? 8'h20 : 8'h1F, 8'h7D, 1'b1);
            check("frz_hs", 32'(hs_o), 32'd0);
        end
        ce = 1'b1;
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_px("resume", 8'h00, 8'h00, 8'h00, 1'b0);

        // Line y=2, x=0: threshold 0.
        drive(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_px("l2x0", 8'h10, 8'h10, 8'h40, 1'b1);

        // Line y=3: x=0 threshold 3 saturates 0xFF; x=1 threshold 1 on 0xFB.
        drive(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'hFB, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("sat", 8'h3F, 8'h3F, 8'hFF, 1'b1);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_px("l3x1", Dith ? 8'h3F : 8'h3E, Dith ? 8'h3F : 8'h3E, 8'hFB, 1'b1);

        // New frame: VS rising edge during blanking advances f in u_tmp only.
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("vs_dly", 32'(vs_o), 32'd1);
        check("vs_tdly", 32'(t_vs), 32'd1);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("vs_fall", 32'(vs_o), 32'd0);

        // Line y=0 with f=1 in u_tmp: its thresholds become 2,0,2,0.
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("f1x0", 8'h20, Dith ? 8'h21 : 8'h20, 8'h82, 1'b1);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("f1x1", Dith ? 8'h21 : 8'h20, 8'h20, 8'h82, 1'b1);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("f1x2", 8'h20, Dith ? 8'h21 : 8'h20, 8'h82, 1'b1);
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_px("f1x3", Dith ? 8'h21 : 8'h20, 8'h20, 8'h82, 1'b1);

        // Line y=1 interrupted by reset.
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("prerst", Dith ? 8'h21 : 8'h20, 8'h20, 8'h82, 1'b1);
        rst_n = 1'b0;
        #2;
        chk_px("rstasync", 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b1;
        drive(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("rstlat", 8'h00, 8'h00, 8'h00, 1'b0);
        drive(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_px("rstpix", 8'h10, 8'h10, 8'h40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
